// File: rtl/ifu_pkg.sv
// ifu_pkg: opcode constants, fetch-queue entry type and RISC-V immediate decoders shared by the fetch unit.
package ifu_pkg;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pnpc;
    } fq_entry_t;
    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction
    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction
endpackage

// File: rtl/ifu_fq_if.sv
// ifu_fq_if: fetch-unit bus bundle.
//   icache_addr/icache_hit/icache_inst  ICache lookup
//   jump_flush/jump_dnpc, cs_flush/cs_dnpc  redirects
//   out_valid/out_ready/out_pc/out_inst/out_pnpc  fetch-queue head towards IDU
//   master = fetch unit side, slave = environment side
interface ifu_fq_if;
    logic [31:0] icache_addr, icache_inst, jump_dnpc, cs_dnpc, out_pc, out_inst, out_pnpc;
    logic        icache_hit, jump_flush, cs_flush, out_ready, out_valid;
    modport master(
        output icache_addr, out_valid, out_pc, out_inst, out_pnpc,
        input  icache_hit, icache_inst, jump_flush, jump_dnpc, cs_flush, cs_dnpc, out_ready
    );
    modport slave(
        input  icache_addr, out_valid, out_pc, out_inst, out_pnpc,
        output icache_hit, icache_inst, jump_flush, jump_dnpc, cs_flush, cs_dnpc, out_ready
    );
endinterface

// File: rtl/ifu_fq_buf.sv
// ifu_fq_buf: FIFO of fetch-queue entries.
//   clock, reset   clock, synchronous active-high reset
//   push, pop      enqueue din / dequeue head
//   clear          drop every entry (pipeline flush)
//   full, empty, count, head   status and head entry (zero while empty)
module ifu_fq_buf
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  fq_entry_t                din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output fq_entry_t                head
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wp, rp;
    fq_entry_t   mem [DEPTH];
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clock) begin
        if (push) mem[wp[AW-1:0]] <= din;
    end
    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign count = wp - rp;
    assign head  = empty ? '0 : mem[rp[AW-1:0]];
endmodule

// File: rtl/ifu_fq.sv
// ifu_fq: instruction fetch unit with static prediction and a fetch queue in front of IDU.
//   clock, reset  clock, synchronous active-high reset
//   bus           ifu_fq_if.master: ICache lookup, redirects, queue head handshake
//   fq_count      occupied queue entries
//   IFU_BTFN_EN   when defined, backward branches are predicted taken
module ifu_fq
    import ifu_pkg::*;
#(
    parameter int          FQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                       clock,
    input  logic                       reset,
    ifu_fq_if.master                   bus,
    output logic [$clog2(FQ_DEPTH):0]  fq_count
);
    logic [31:0] fetch_pc, seq_pc, br_pred, pred;
    logic [4:0]  opc;
    logic        halt, flush, push, pop, full, empty;
    fq_entry_t   head;
    assign opc    = bus.icache_inst[6:2];
    assign seq_pc = fetch_pc + 32'd4;
`ifdef IFU_BTFN_EN
    assign br_pred = bus.icache_inst[31] ? fetch_pc + imm_b(bus.icache_inst) : seq_pc;
`else
    assign br_pred = seq_pc;
`endif
    always_comb begin
        pred = seq_pc;
        pred = opc == OPC_JAL ? fetch_pc + imm_j(bus.icache_inst) : opc == OPC_BRANCH ? br_pred : seq_pc;
    end
    assign flush         = bus.jump_flush | bus.cs_flush;
    assign bus.out_valid = ~empty & ~flush;
    assign pop           = bus.out_valid & bus.out_ready;
    assign push          = bus.icache_hit & ~halt & ~flush & (~full | pop);
    // Redirects need no pending state: the ICache copes with the address moving mid-refill.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            halt     <= 1'b0;
        end else if (flush) begin
            fetch_pc <= bus.cs_flush ? bus.cs_dnpc : bus.jump_dnpc;
            halt     <= 1'b0;
        end else if (push) begin
            fetch_pc <= pred;
            halt     <= opc == OPC_SYSTEM;
        end
    end
    ifu_fq_buf #(.DEPTH(FQ_DEPTH)) u_buf (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .din   ('{pc: fetch_pc, inst: bus.icache_inst, pnpc: pred}),
        .full  (full),
        .empty (empty),
        .count (fq_count),
        .head  (head)
    );
    assign bus.icache_addr = fetch_pc;
    assign bus.out_pc      = head.pc;
    assign bus.out_inst    = head.inst;
    assign bus.out_pnpc    = head.pnpc;
endmodule

// File: tb/tb_ifu_fq.sv
// tb_ifu_fq: randomized and directed check of ifu_fq against a queue-based reference model.
module tb_ifu_fq;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int D = 4;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pnpc;
    } ent_t;
    logic clock = 1'b0, reset = 1'b1;
    logic [2:0] fq_count;
    ifu_fq_if bus();
    ifu_fq #(.FQ_DEPTH(D), .RESET_PC(RST_PC)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus.master),
        .fq_count (fq_count)
    );
    always #5 clock = ~clock;
    int checks = 0, errors = 0;
    ent_t q[$];
    logic [31:0] m_pc;
    bit m_halt;
    bit hit, rdy, jf, cf, r;
    int kind, off;
    logic [31:0] jd, cd;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    // kind: 0 ADDI, 1 JAL, 2 BEQ, 3 ECALL; off is the branch/jump byte offset
    function automatic logic [31:0] enc(input int k, input int o);
        logic [31:0] v = o;
        case (k)
            1: return {v[20], v[10:1], v[11], v[19:12], 5'd1, 7'b1101111};
            2: return {v[12], v[10:5], 5'd2, 5'd1, 3'b000, v[4:1], v[11], 7'b1100011};
            3: return 32'h0000_0073;
            default: return 32'h00a0_0093;
        endcase
    endfunction
    function automatic logic [31:0] predict(input logic [31:0] pc, input int k, input int o);
        if (k == 1) return pc + o;
`ifdef IFU_BTFN_EN
        if (k == 2 && o < 0) return pc + o;
`endif
        return pc + 32'd4;
    endfunction
    task automatic cyc();
        logic [31:0] inst, pr;
        ent_t h;
        bit fl, ev, p_pop, p_push;
        inst = enc(kind, off);
        bus.icache_hit = hit;
        bus.icache_inst = inst;
        bus.out_ready = rdy;
        bus.jump_flush = jf;
        bus.jump_dnpc = jd;
        bus.cs_flush = cf;
        bus.cs_dnpc = cd;
        reset = r;
        #1;
        fl = jf | cf;
        ev = q.size() > 0 && !fl;
        h = q.size() > 0 ? q[0] : '{32'd0, 32'd0, 32'd0};
        chk("icache_addr", bus.icache_addr, m_pc);
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, ev});
        chk("out_pc", bus.out_pc, h.pc);
        chk("out_inst", bus.out_inst, h.inst);
        chk("out_pnpc", bus.out_pnpc, h.pnpc);
        chk("fq_count", {29'd0, fq_count}, q.size());
        pr = predict(m_pc, kind, off);
        @(posedge clock);
        if (r) begin
            q.delete();
            m_pc = RST_PC;
            m_halt = 0;
        end else if (fl) begin
            q.delete();
            m_pc = cf ? cd : jd;
            m_halt = 0;
        end else begin
            p_pop = ev && rdy;
            p_push = hit && !m_halt && (q.size() < D || p_pop);
            if (p_pop) void'(q.pop_front());
            if (p_push) begin
                q.push_back('{m_pc, inst, pr});
                m_pc = pr;
                if (kind == 3) m_halt = 1;
            end
        end
        @(negedge clock);
    endtask
    task automatic go(input bit h, input int k, input int o, input bit rd);
        hit = h; kind = k; off = o; rdy = rd; jf = 0; cf = 0; r = 0;
        cyc();
    endtask
    task automatic rst();
        hit = 0; kind = 0; off = 0; rdy = 0; jf = 0; cf = 0; r = 1;
        cyc();
        r = 0;
    endtask
    initial begin
        jd = '0; cd = '0;
        bus.icache_hit = 0; bus.icache_inst = '0; bus.out_ready = 0;
        bus.jump_flush = 0; bus.cs_flush = 0; bus.jump_dnpc = '0; bus.cs_dnpc = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        m_pc = RST_PC; m_halt = 0; q.delete();
        // sequential stream, one entry per cycle
        for (int i = 0; i < 8; i++) go(1, 0, 0, 1);
        // fill to full, then simultaneous push and pop
        rst();
        for (int i = 0; i < 6; i++) go(1, 0, 0, 0);
        chk("full_count", {29'd0, fq_count}, 4);
        chk("full_addr", bus.icache_addr, 32'h8000_0010);
        go(1, 0, 0, 1);
        chk("full_pushpop_count", {29'd0, fq_count}, 4);
        chk("full_pushpop_addr", bus.icache_addr, 32'h8000_0014);
        // JAL +0x100 at 0x80000008
        rst();
        go(1, 0, 0, 1); go(1, 0, 0, 1); go(1, 1, 256, 1);
        chk("jal_addr", bus.icache_addr, 32'h8000_0108);
        for (int i = 0; i < 3; i++) go(1, 0, 0, 1);
        // forward BEQ at 0x80000010
        rst();
        for (int i = 0; i < 4; i++) go(1, 0, 0, 1);
        go(1, 2, 16, 1);
        chk("beq_fwd_addr", bus.icache_addr, 32'h8000_0014);
        // backward BEQ at 0x80000010
        rst();
        for (int i = 0; i < 4; i++) go(1, 0, 0, 1);
        go(1, 2, -8, 1);
`ifdef IFU_BTFN_EN
        chk("beq_bwd_addr", bus.icache_addr, 32'h8000_0008);
`else
        chk("beq_bwd_addr", bus.icache_addr, 32'h8000_0014);
`endif
        go(0, 0, 0, 1); go(0, 0, 0, 1);
        // both redirects in one cycle with 3 entries queued
        rst();
        for (int i = 0; i < 3; i++) go(1, 0, 0, 0);
        hit = 1; kind = 0; rdy = 1; jf = 1; cf = 1; jd = 32'h8000_0200; cd = 32'h8000_0400;
        cyc();
        chk("flush_count", {29'd0, fq_count}, 0);
        chk("flush_addr", bus.icache_addr, 32'h8000_0400);
        go(1, 0, 0, 1); go(1, 0, 0, 1);
        // ECALL halts fetch until a redirect; misses add nothing
        rst();
        go(1, 3, 0, 0);
        for (int i = 0; i < 20; i++) go(1, 0, 0, 0);
        chk("halt_count", {29'd0, fq_count}, 1);
        chk("halt_addr", bus.icache_addr, 32'h8000_0004);
        hit = 1; kind = 0; rdy = 0; jf = 0; cf = 1; cd = 32'h8000_0800;
        cyc();
        go(1, 0, 0, 0); go(0, 0, 0, 0); go(1, 0, 0, 0); go(0, 0, 0, 0);
        chk("resume_addr", bus.icache_addr, 32'h8000_0808);
        chk("resume_count", {29'd0, fq_count}, 2);
        go(0, 0, 0, 1); go(0, 0, 0, 1); go(0, 0, 0, 1);
        // randomized traffic
        rst();
        for (int i = 0; i < 3000; i++) begin
            int s;
            hit = $urandom_range(0, 3) != 0;
            s = $urandom_range(0, 19);
            kind = s < 12 ? 0 : s < 15 ? 1 : s < 19 ? 2 : 3;
            off = ($urandom_range(0, 2047) - 1024) * 2;
            rdy = $urandom_range(0, 4) < 3;
            jf = $urandom_range(0, 24) == 0;
            cf = $urandom_range(0, 39) == 0;
            jd = $urandom & 32'hffff_fffc;
            cd = $urandom & 32'hffff_fffc;
            r = $urandom_range(0, 299) == 0;
            cyc();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
